// File: rtl/sim_run_sequencer_if.sv
// Control/status bundle between the run sequencer and the logic it drives and observes.
// master is the sequencer side; slave is the controller/observer side.
interface sim_run_sequencer_if #(
    parameter int CW = 32
);
    logic          restart_i;
    logic          done_i;
    logic          sub_reset_l;
    logic          running;
    logic [CW-1:0] run_cycles;
    logic          pass_o;
    logic          timeout_o;
    logic [7:0]    run_count;

    modport master (
        input  restart_i, done_i,
        output sub_reset_l, running, run_cycles, pass_o, timeout_o, run_count
    );

    modport slave (
        output restart_i, done_i,
        input  sub_reset_l, running, run_cycles, pass_o, timeout_o, run_count
    );
endinterface

// File: rtl/sim_run_sequencer.sv
// Holds the downstream reset for HOLD_CYCLES, times the run, and reports pass/timeout.
// All outputs are registered (one-cycle response to restart/done); no backpressure, inputs are pulses.
module sim_run_sequencer #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CW             = 32
) (
    input  logic                 clk,
    input  logic                 reset_l,
    sim_run_sequencer_if.master  sif
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] run_cycles_q;

    assign sif.run_cycles = run_cycles_q;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state           <= S_HOLD;
            hold_cnt        <= '0;
            run_cycles_q    <= '0;
            sif.sub_reset_l <= 1'b0;
            sif.running     <= 1'b0;
            sif.pass_o      <= 1'b0;
            sif.timeout_o   <= 1'b0;
            sif.run_count   <= 8'd0;
        end else if (sif.restart_i) begin
            // Restart outranks done and timeout, even mid-run.
            state           <= S_HOLD;
            hold_cnt        <= '0;
            run_cycles_q    <= '0;
            sif.sub_reset_l <= 1'b0;
            sif.running     <= 1'b0;
            sif.pass_o      <= 1'b0;
            sif.timeout_o   <= 1'b0;
            if (sif.run_count != 8'd255) begin
                sif.run_count <= sif.run_count + 8'd1;
            end
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state           <= S_RUN;
                        hold_cnt        <= '0;
                        sif.sub_reset_l <= 1'b1;
                        sif.running     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    // run_cycles freezes on the exit edge so it reports the last RUN cycle index.
                    if (sif.done_i) begin
                        state           <= S_PASS;
                        sif.pass_o      <= 1'b1;
                        sif.sub_reset_l <= 1'b0;
                        sif.running     <= 1'b0;
                    end else if (run_cycles_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state           <= S_FAIL;
                        sif.timeout_o   <= 1'b1;
                        sif.sub_reset_l <= 1'b0;
                        sif.running     <= 1'b0;
                    end else begin
                        run_cycles_q <= run_cycles_q + CW'(1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sim_run_sequencer.sv
// Drives two sequencers (default and short-timeout) with shared directed and random stimulus,
// comparing every cycle against a cycle-index model of the run sequence.
module tb_sim_run_sequencer;
    localparam int HOLD  = 4;
    localparam int TO_A  = 100;
    localparam int TO_B  = 10;

    logic clk = 1'b0;
    logic rst_l;
    logic restart;
    logic done;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sim_run_sequencer_if #(.CW(32)) ifa ();
    sim_run_sequencer_if #(.CW(32)) ifb ();

    assign ifa.restart_i = restart;
    assign ifa.done_i    = done;
    assign ifb.restart_i = restart;
    assign ifb.done_i    = done;

    sim_run_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO_A), .CW(32)) dut_a (
        .clk(clk), .reset_l(rst_l), .sif(ifa)
    );
    sim_run_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO_B), .CW(32)) dut_b (
        .clk(clk), .reset_l(rst_l), .sif(ifb)
    );

    // t: cycles since the sequence started; ended: 0 running/holding, 1 pass, 2 timeout.
    typedef struct {
        int t;
        int ended;
        int end_rc;
        int rc;
    } mdl_t;

    mdl_t ma, mb;
    bit   valid = 1'b0;

    function automatic mdl_t step(mdl_t m, bit rl, bit rs, bit dn, int hold, int to);
        mdl_t n = m;
        if (!rl) begin
            n = '{0, 0, 0, 0};
        end else if (rs) begin
            n.t = 0;
            n.ended = 0;
            n.end_rc = 0;
            if (n.rc < 255) n.rc = n.rc + 1;
        end else if (n.ended == 0) begin
            if (n.t >= hold) begin
                if (dn) begin
                    n.ended = 1;
                    n.end_rc = n.t - hold;
                end else if (n.t - hold == to - 1) begin
                    n.ended = 2;
                    n.end_rc = n.t - hold;
                end else begin
                    n.t = n.t + 1;
                end
            end else begin
                n.t = n.t + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, rst_l, restart, done, HOLD, TO_A);
        mb <= step(mb, rst_l, restart, done, HOLD, TO_B);
        if (!rst_l) valid <= 1'b1;
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(string tag, mdl_t m, int hold, int sub, int run, int rc,
                            int ps, int tmo, int cnt);
        int e_sub, e_run, e_rc, e_ps, e_tmo;
        if (m.ended != 0) begin
            e_sub = 0; e_run = 0; e_rc = m.end_rc;
            e_ps = (m.ended == 1) ? 1 : 0;
            e_tmo = (m.ended == 2) ? 1 : 0;
        end else if (m.t < hold) begin
            e_sub = 0; e_run = 0; e_rc = 0; e_ps = 0; e_tmo = 0;
        end else begin
            e_sub = 1; e_run = 1; e_rc = m.t - hold; e_ps = 0; e_tmo = 0;
        end
        chk({tag, ".sub_reset_l"}, sub, e_sub);
        chk({tag, ".running"}, run, e_run);
        chk({tag, ".run_cycles"}, rc, e_rc);
        chk({tag, ".pass_o"}, ps, e_ps);
        chk({tag, ".timeout_o"}, tmo, e_tmo);
        chk({tag, ".run_count"}, cnt, m.rc);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            cmp_inst("model_a", ma, HOLD, int'(ifa.sub_reset_l), int'(ifa.running),
                     int'(ifa.run_cycles), int'(ifa.pass_o), int'(ifa.timeout_o),
                     int'(ifa.run_count));
            cmp_inst("model_b", mb, HOLD, int'(ifb.sub_reset_l), int'(ifb.running),
                     int'(ifb.run_cycles), int'(ifb.pass_o), int'(ifb.timeout_o),
                     int'(ifb.run_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        rst_l = 1'b0;
        restart = 1'b0;
        done = 1'b0;
        repeat (2) tick();
        rst_l = 1'b1;

        // Cycle 0 after reset: reset values.
        @(negedge clk);
        chk("rst.sub_reset_l", int'(ifa.sub_reset_l), 0);
        chk("rst.running", int'(ifa.running), 0);
        chk("rst.pass_o", int'(ifa.pass_o), 0);
        chk("rst.run_count", int'(ifa.run_count), 0);
        repeat (3) tick();
        @(negedge clk);
        chk("c3.sub_reset_l", int'(ifa.sub_reset_l), 0);
        tick();
        @(negedge clk);
        chk("c4.sub_reset_l", int'(ifa.sub_reset_l), 1);
        chk("c4.running", int'(ifa.running), 1);
        repeat (100) tick();
        @(negedge clk);
        chk("c104.timeout_o", int'(ifa.timeout_o), 1);
        chk("c104.run_cycles", int'(ifa.run_cycles), 99);
        chk("c104.sub_reset_l", int'(ifa.sub_reset_l), 0);
        chk("c104.pass_o", int'(ifa.pass_o), 0);

        // done at RUN cycle 3.
        pulse_restart();
        repeat (7) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge clk);
        chk("done3.pass_o", int'(ifa.pass_o), 1);
        chk("done3.run_cycles", int'(ifa.run_cycles), 3);
        chk("done3.timeout_o", int'(ifa.timeout_o), 0);
        chk("done3.sub_reset_l", int'(ifa.sub_reset_l), 0);
        chk("done3.run_count", int'(ifa.run_count), 1);

        // done coincides with the timeout cycle of the short-timeout instance.
        pulse_restart();
        repeat (13) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge clk);
        chk("tie.pass_o", int'(ifb.pass_o), 1);
        chk("tie.timeout_o", int'(ifb.timeout_o), 0);
        chk("tie.run_cycles", int'(ifb.run_cycles), 9);

        // restart and done together in RUN cycle 5.
        pulse_restart();
        repeat (9) tick();
        restart = 1'b1;
        done = 1'b1;
        tick();
        restart = 1'b0;
        done = 1'b0;
        @(negedge clk);
        chk("abort.pass_o", int'(ifa.pass_o), 0);
        chk("abort.run_cycles", int'(ifa.run_cycles), 0);
        chk("abort.running", int'(ifa.running), 0);
        chk("abort.run_count", int'(ifa.run_count), 4);
        repeat (3) tick();
        @(negedge clk);
        chk("abort.c3.sub_reset_l", int'(ifa.sub_reset_l), 0);
        tick();
        @(negedge clk);
        chk("abort.c4.running", int'(ifa.running), 1);
        chk("abort.c4.run_cycles", int'(ifa.run_cycles), 0);

        // Many restarts with done noise in HOLD, RUN and PASS.
        for (int i = 0; i < 256; i++) begin
            pulse_restart();
            repeat (6 + int'($urandom_range(0, 6))) begin
                done = ($urandom_range(0, 1) == 1);
                tick();
            end
            done = 1'b0;
        end
        @(negedge clk);
        chk("sat.run_count", int'(ifa.run_count), 255);

        // Random traffic including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst_l   = ($urandom_range(0, 199) != 0);
            restart = ($urandom_range(0, 39) == 0);
            done    = ($urandom_range(0, 7) == 0);
            tick();
        end
        rst_l = 1'b1;
        restart = 1'b0;
        done = 1'b0;

        // reset_l low during RUN cycle 7.
        pulse_restart();
        repeat (11) tick();
        restart = 1'b1;
        rst_l = 1'b0;
        tick();
        restart = 1'b0;
        rst_l = 1'b1;
        @(negedge clk);
        chk("mid_rst.run_count", int'(ifa.run_count), 0);
        chk("mid_rst.running", int'(ifa.running), 0);
        chk("mid_rst.run_cycles", int'(ifa.run_cycles), 0);
        chk("mid_rst.sub_reset_l", int'(ifa.sub_reset_l), 0);
        repeat (4) tick();
        @(negedge clk);
        chk("mid_rst.c4.running", int'(ifa.running), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
